// File: rtl/inst_pc_sequencer_pkg.sv
// ============================================================================
// Module  : inst_mem_pkg
// Brief   : Shared types and loop-mode constants for the PC sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package inst_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam logic [1:0] LOOP_DISABLE = 2'd0;
    localparam logic [1:0] LOOP_1D      = 2'd1;
    localparam logic [1:0] LOOP_2D      = 2'd2;
    localparam logic [1:0] LOOP_3D      = 2'd3;

endpackage

`default_nettype wire

// File: rtl/inst_pc_sequencer_if.sv
// ============================================================================
// Module  : inst_pc_sequencer_if
// Brief   : Control/fetch bundle of the PC sequencer. Perf outputs exist only
//           when INST_PC_SEQ_PERF_CNT_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface inst_pc_sequencer_if #(
    parameter int InstMemAddrWidth = 32,
    parameter int LoopNumWidth     = 2
);
    logic                        start_i;
    logic                        stall_i;
    logic                        dbg_en_i;
    logic                        dbg_step_i;
    logic [LoopNumWidth-1:0]     inst_loop_mode_i;
    logic [InstMemAddrWidth-1:0] inst_last_addr_i;
    logic                        inst_jump_i;
    logic [InstMemAddrWidth-1:0] inst_jump_addr_i;
    logic                        inst_loop_done_i;
    logic [InstMemAddrWidth-1:0] inst_pc_o;
    logic                        inst_rd_en_o;
    logic                        inst_adv_o;
    logic                        inst_clr_o;
    logic                        busy_o;
    logic                        done_o;
`ifdef INST_PC_SEQ_PERF_CNT_EN
    logic [31:0]                 perf_retired_o;
    logic [31:0]                 perf_stall_o;
`endif

    // master: the sequencer itself; slave: CSR / loop-control / memory side
    modport master (
        input  start_i, stall_i, dbg_en_i, dbg_step_i, inst_loop_mode_i,
               inst_last_addr_i, inst_jump_i, inst_jump_addr_i, inst_loop_done_i,
`ifdef INST_PC_SEQ_PERF_CNT_EN
        output perf_retired_o, perf_stall_o,
`endif
        output inst_pc_o, inst_rd_en_o, inst_adv_o, inst_clr_o, busy_o, done_o
    );

    modport slave (
        output start_i, stall_i, dbg_en_i, dbg_step_i, inst_loop_mode_i,
               inst_last_addr_i, inst_jump_i, inst_jump_addr_i, inst_loop_done_i,
`ifdef INST_PC_SEQ_PERF_CNT_EN
        input  perf_retired_o, perf_stall_o,
`endif
        input  inst_pc_o, inst_rd_en_o, inst_adv_o, inst_clr_o, busy_o, done_o
    );

endinterface

`default_nettype wire

// File: rtl/inst_pc_sequencer_perf_cnt.sv
// ============================================================================
// Module  : inst_perf_cnt
// Brief   : 32-bit saturating event counter with synchronous clear.
// Revision: 1.0
// ============================================================================
`default_nettype none

module inst_perf_cnt (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    input  wire logic        i_clr,
    input  wire logic        i_en,
    output logic [31:0]      o_cnt
);
    logic [31:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !(&r_cnt)) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/inst_pc_sequencer.sv
// ============================================================================
// Module  : inst_pc_sequencer
// Brief   : Instruction PC sequencer (IDLE/RUN/DONE) with stall/debug
//           qualification. Optional perf counters: INST_PC_SEQ_PERF_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module inst_pc_sequencer
    import inst_mem_pkg::*;
#(
    parameter int InstMemAddrWidth = 32,
    parameter int LoopNumWidth     = 2
) (
    input  wire logic            clk_i,
    input  wire logic            rst_i,
    inst_pc_sequencer_if.master  io_seq
);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]                  r_state;
    logic [InstMemAddrWidth-1:0] r_pc;
    logic                        w_run;
    logic                        w_start;
    logic                        w_adv;
    logic                        w_fin;

    assign w_run   = (r_state == S_RUN);
    assign w_start = (r_state == S_IDLE) && io_seq.start_i;
    // Stall beats a debug step; a step seen while stalled is simply lost.
    assign w_adv   = w_run && !io_seq.stall_i && (!io_seq.dbg_en_i || io_seq.dbg_step_i);
    assign w_fin   = (io_seq.inst_loop_mode_i == LoopNumWidth'(LOOP_DISABLE))
                   ? (r_pc == io_seq.inst_last_addr_i)
                   : io_seq.inst_loop_done_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_seq.start_i) begin
                        r_pc    <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_adv) begin
                        if (w_fin) begin
                            r_state <= S_DONE;
                        end else if (io_seq.inst_jump_i) begin
                            r_pc <= io_seq.inst_jump_addr_i;
                        end else begin
                            r_pc <= r_pc + 1'b1;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_seq.inst_pc_o    = r_pc;
    assign io_seq.inst_rd_en_o = w_run;
    assign io_seq.inst_adv_o   = w_adv;
    assign io_seq.inst_clr_o   = w_start || (r_state == S_DONE);
    assign io_seq.busy_o       = (r_state != S_IDLE);
    assign io_seq.done_o       = (r_state == S_DONE);

`ifdef INST_PC_SEQ_PERF_CNT_EN
    logic [31:0] w_retired;
    logic [31:0] w_stalled;

    inst_perf_cnt u_retired (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .i_clr (w_start),
        .i_en  (w_adv),
        .o_cnt (w_retired)
    );

    inst_perf_cnt u_stalled (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .i_clr (w_start),
        .i_en  (w_run && io_seq.stall_i),
        .o_cnt (w_stalled)
    );

    assign io_seq.perf_retired_o = w_retired;
    assign io_seq.perf_stall_o   = w_stalled;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_pc_sequencer.sv
// ============================================================================
// Module  : tb_inst_pc_sequencer
// Brief   : Directed self-checking bench for inst_pc_sequencer (32-bit and
//           4-bit instances).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_inst_pc_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_pc_sequencer_if #(.InstMemAddrWidth(32), .LoopNumWidth(2)) bus_a ();
    inst_pc_sequencer_if #(.InstMemAddrWidth(4),  .LoopNumWidth(2)) bus_b ();

    inst_pc_sequencer #(.InstMemAddrWidth(32), .LoopNumWidth(2)) dut_a (
        .clk_i  (clk),
        .rst_i  (rst),
        .io_seq (bus_a)
    );

    inst_pc_sequencer #(.InstMemAddrWidth(4), .LoopNumWidth(2)) dut_b (
        .clk_i  (clk),
        .rst_i  (rst),
        .io_seq (bus_b)
    );

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check the same-cycle outputs, queue the post-edge expectation, clock, compare.
    task automatic cyc(input string tag, input logic e_adv, input logic e_clr,
                       input logic e_done, input logic [31:0] e_pc, input logic e_busy);
        exp_t e;
        #1;
        chk({tag, ":adv"},  {31'd0, bus_a.inst_adv_o}, {31'd0, e_adv});
        chk({tag, ":clr"},  {31'd0, bus_a.inst_clr_o}, {31'd0, e_clr});
        chk({tag, ":done"}, {31'd0, bus_a.done_o},     {31'd0, e_done});
        exp_q.push_back('{tag: tag, pc: e_pc, busy: e_busy});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({e.tag, ":pc"},   bus_a.inst_pc_o,         e.pc);
        chk({e.tag, ":busy"}, {31'd0, bus_a.busy_o},   {31'd0, e.busy});
    endtask

    initial begin
        bus_a.start_i = 0; bus_a.stall_i = 0; bus_a.dbg_en_i = 0; bus_a.dbg_step_i = 0;
        bus_a.inst_loop_mode_i = 2'd0; bus_a.inst_last_addr_i = 32'd5;
        bus_a.inst_jump_i = 0; bus_a.inst_jump_addr_i = 32'd0; bus_a.inst_loop_done_i = 0;
        bus_b.start_i = 0; bus_b.stall_i = 0; bus_b.dbg_en_i = 0; bus_b.dbg_step_i = 0;
        bus_b.inst_loop_mode_i = 2'd0; bus_b.inst_last_addr_i = 4'd3;
        bus_b.inst_jump_i = 0; bus_b.inst_jump_addr_i = 4'd0; bus_b.inst_loop_done_i = 0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst:pc",    bus_a.inst_pc_o,              32'd0);
        chk("rst:busy",  {31'd0, bus_a.busy_o},        32'd0);
        chk("rst:done",  {31'd0, bus_a.done_o},        32'd0);
        chk("rst:rd_en", {31'd0, bus_a.inst_rd_en_o},  32'd0);
        chk("rst:adv",   {31'd0, bus_a.inst_adv_o},    32'd0);
        chk("rst:clr",   {31'd0, bus_a.inst_clr_o},    32'd0);
        rst = 0;

        // Linear run 0..5; start held into DONE must be ignored
        bus_a.start_i = 1;
        cyc("lin_start", 0, 1, 0, 32'd0, 1);
        bus_a.start_i = 0;
        #1 chk("lin:rd_en", {31'd0, bus_a.inst_rd_en_o}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            cyc("lin_adv", 1, 0, 0, (i < 5) ? 32'(i + 1) : 32'd5, 1);
        end
        bus_a.start_i = 1;
        cyc("lin_done", 0, 1, 1, 32'd5, 0);
        bus_a.start_i = 0;
        cyc("lin_idle", 0, 0, 0, 32'd5, 0);

        // Second program: stall, jump, debug, loop-done
        bus_a.inst_last_addr_i = 32'd20;
        bus_a.start_i = 1;
        cyc("p2_start", 0, 1, 0, 32'd0, 1);
        bus_a.start_i = 0;
        for (int i = 0; i < 3; i++) cyc("p2_adv", 1, 0, 0, 32'(i + 1), 1);
        bus_a.stall_i = 1;
        cyc("stall1", 0, 0, 0, 32'd3, 1);
        bus_a.start_i = 1;
        cyc("stall2_start", 0, 0, 0, 32'd3, 1);
        bus_a.start_i = 0;
        cyc("stall3", 0, 0, 0, 32'd3, 1);
        bus_a.stall_i = 0;
        cyc("unstall", 1, 0, 0, 32'd4, 1);
        bus_a.inst_jump_i = 1; bus_a.inst_jump_addr_i = 32'd2;
        cyc("jump", 1, 0, 0, 32'd2, 1);
        bus_a.inst_jump_i = 0;
        cyc("post_jump", 1, 0, 0, 32'd3, 1);

        bus_a.dbg_en_i = 1;
        cyc("dbg_hold1", 0, 0, 0, 32'd3, 1);
        cyc("dbg_hold2", 0, 0, 0, 32'd3, 1);
        bus_a.dbg_step_i = 1;
        cyc("dbg_step1", 1, 0, 0, 32'd4, 1);
        bus_a.dbg_step_i = 0;
        cyc("dbg_gap", 0, 0, 0, 32'd4, 1);
        bus_a.dbg_step_i = 1;
        cyc("dbg_step2", 1, 0, 0, 32'd5, 1);
        bus_a.stall_i = 1;
        cyc("dbg_step_stall", 0, 0, 0, 32'd5, 1);
        bus_a.stall_i = 0; bus_a.dbg_step_i = 0; bus_a.dbg_en_i = 0;

        bus_a.inst_loop_mode_i = 2'd1; bus_a.inst_loop_done_i = 1;
        bus_a.inst_jump_i = 1; bus_a.inst_jump_addr_i = 32'd9;
        cyc("ldone_fin", 1, 0, 0, 32'd5, 1);
        bus_a.inst_loop_done_i = 0; bus_a.inst_jump_i = 0; bus_a.inst_loop_mode_i = 2'd0;
        cyc("ldone_done", 0, 1, 1, 32'd5, 0);

        // Reset mid-run at PC=7
        bus_a.start_i = 1;
        cyc("p3_start", 0, 1, 0, 32'd0, 1);
        bus_a.start_i = 0;
        for (int i = 0; i < 7; i++) cyc("p3_adv", 1, 0, 0, 32'(i + 1), 1);
        rst = 1;
        cyc("rst_mid", 1, 0, 0, 32'd0, 0);
        rst = 0;
        cyc("rst_after", 0, 0, 0, 32'd0, 0);

        // 4-bit instance: PC 15 wraps to 0
        bus_b.start_i = 1;
        @(posedge clk); #1;
        chk("w:start_pc", {28'd0, bus_b.inst_pc_o}, 32'd0);
        bus_b.start_i = 0;
        bus_b.inst_jump_i = 1; bus_b.inst_jump_addr_i = 4'd14;
        @(posedge clk); #1;
        chk("w:jump_pc", {28'd0, bus_b.inst_pc_o}, 32'd14);
        bus_b.inst_jump_i = 0;
        @(posedge clk); #1;
        chk("w:pc15", {28'd0, bus_b.inst_pc_o}, 32'd15);
        @(posedge clk); #1;
        chk("w:wrap", {28'd0, bus_b.inst_pc_o}, 32'd0);
        chk("w:busy", {31'd0, bus_b.busy_o},    32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
